// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and the default operand width.
package serial_add_pkg;

  localparam int unsigned SERIAL_ADD_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bit_slice_fa.sv
// One-bit full adder built from two half-adder cells; the carry out is
// the OR of the two half-adder carries (they can never both be set).
module bit_slice_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic s_ab;
  logic c_ab;
  logic c_sc;

  ha_cell u_ha_ab (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s_ab),
    .c_o (c_ab)
  );

  ha_cell u_ha_sc (
    .a_i (s_ab),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (c_sc)
  );

  assign c_o = c_ab | c_sc;

endmodule

// File: rtl/ha_cell.sv
// Half-adder cell: sum and carry of two input bits.
module ha_cell (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Sequences one shared full-adder slice over
// two WIDTH-bit operands, LSB first, one bit per clock.
// Optional feature macro: SERIAL_ADD_SUB_EN adds the op port; op=1 loads
// operand B inverted with carry-in set, producing A - B (carry_out=1 means
// no borrow).
//
// state | meaning
// IDLE  | waiting for start; sum/carry_out hold the last result
// RUN   | one sum bit per cycle, WIDTH cycles
// DONE  | one-cycle done pulse, result valid
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  logic [WIDTH-1:0]  b_load;
  logic              carry_init;
  logic              fa_s;
  logic              fa_c;

  bit_slice_fa u_fa (
    .a_i (opa_q[0]),
    .b_i (opb_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // Operand B and carry-in as loaded on accept (inverted/set for subtract).
  always_comb begin
    b_load     = b;
    carry_init = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    if (op) begin
      b_load     = ~b;
      carry_init = 1'b1;
    end
`endif
  end

  // Next-state and datapath update for the FSM, counter and shift registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          opa_d   = a;
          opb_d   = b_load;
          carry_d = carry_init;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
        end
      end
      RUN: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = fa_c;
        if (cnt_q == CNT_LAST) begin
          // Counter parks at its last value rather than wrapping.
          state_d = DONE;
          cout_d  = fa_c;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule
